// File: rtl/mm_resp_if.sv
// mm_resp_if: CPU request/response and module-side bus of the mm_resp responder.
interface mm_resp_if;
  logic        cpu_de;
  logic        cpu_we;
  logic [7:0]  cpu_mod;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_rdy;
  logic        cpu_err;
  logic [15:0] mod_sel;
  logic        mod_we;
  logic [31:0] mod_addr;
  logic [31:0] mod_wdata;
  logic [15:0] mod_ack;
  logic [31:0] mod_rdata;
  modport slave (
    input  cpu_de, cpu_we, cpu_mod, cpu_addr, cpu_wdata, mod_ack, mod_rdata,
    output cpu_rdata, cpu_stall, cpu_rdy, cpu_err, mod_sel, mod_we, mod_addr, mod_wdata
  );
  modport master (
    output cpu_de, cpu_we, cpu_mod, cpu_addr, cpu_wdata, mod_ack, mod_rdata,
    input  cpu_rdata, cpu_stall, cpu_rdy, cpu_err, mod_sel, mod_we, mod_addr, mod_wdata
  );
endinterface

// File: rtl/mm_resp.sv
// mm_resp: latches a CPU access, selects one module and returns its ack/data as a one-cycle response.
// Optional ack timeout enabled by MM_RESP_TIMEOUT_EN.
module mm_resp #(
  parameter int TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst,
  mm_resp_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state, state_nx;
  logic [15:0] sel, sel_nx;
  logic        we, we_nx;
  logic [31:0] addr, addr_nx, wdata, wdata_nx, rdata, rdata_nx;
  logic        stall, stall_nx, rdy, rdy_nx, err, err_nx;
  logic        valid, ack;
`ifdef MM_RESP_TIMEOUT_EN
  logic [7:0]  cnt, cnt_nx;
  logic        expire;
  assign expire = cnt == 8'(TIMEOUT - 1);
`endif
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("mm_resp: TIMEOUT must be within 1..255");
  end
  assign valid = bus.cpu_mod <= 8'd4 || (bus.cpu_mod >= 8'd8 && bus.cpu_mod <= 8'd10);
  assign ack   = |(bus.mod_ack & sel);
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    we_nx    = we;
    addr_nx  = addr;
    wdata_nx = wdata;
    rdata_nx = rdata;
    err_nx   = 1'b0;
`ifdef MM_RESP_TIMEOUT_EN
    cnt_nx   = cnt;
`endif
    case (state)
      IDLE: if (bus.cpu_de) begin
        we_nx    = bus.cpu_we;
        addr_nx  = bus.cpu_addr;
        wdata_nx = bus.cpu_wdata;
        sel_nx   = valid ? 16'h1 << bus.cpu_mod[3:0] : 16'h0;
        state_nx = valid ? ACCESS : RESP;
        err_nx   = !valid;
        rdata_nx = valid ? rdata : 32'h0;
`ifdef MM_RESP_TIMEOUT_EN
        cnt_nx   = 8'd0;
`endif
      end
      ACCESS: if (ack) begin
        sel_nx   = 16'h0;
        rdata_nx = we ? 32'h0 : bus.mod_rdata;
        state_nx = RESP;
      end
`ifdef MM_RESP_TIMEOUT_EN
      else if (expire) begin
        sel_nx   = 16'h0;
        rdata_nx = 32'hDEADBEEF;
        err_nx   = 1'b1;
        state_nx = RESP;
      end else cnt_nx = cnt + 8'd1;
`endif
      default: state_nx = IDLE;
    endcase
    stall_nx = state_nx == ACCESS;
    rdy_nx   = state_nx == RESP;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sel   <= '0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
      stall <= 1'b0;
      rdy   <= 1'b0;
      err   <= 1'b0;
`ifdef MM_RESP_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      we    <= we_nx;
      addr  <= addr_nx;
      wdata <= wdata_nx;
      rdata <= rdata_nx;
      stall <= stall_nx;
      rdy   <= rdy_nx;
      err   <= err_nx;
`ifdef MM_RESP_TIMEOUT_EN
      cnt   <= cnt_nx;
`endif
    end
  end
  assign bus.cpu_rdata = rdata;
  assign bus.cpu_stall = stall;
  assign bus.cpu_rdy   = rdy;
  assign bus.cpu_err   = err;
  assign bus.mod_sel   = sel;
  assign bus.mod_we    = we;
  assign bus.mod_addr  = addr;
  assign bus.mod_wdata = wdata;
endmodule

// File: tb/tb_mm_resp.sv
// tb_mm_resp: randomized self-checking bench for mm_resp against a transaction-level model.
module tb_mm_resp;
  localparam int TO = 4;
`ifdef MM_RESP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mm_resp_if bus();
  mm_resp #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  int          o_lat;
  logic        o_err, o_we;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [15:0] o_sel;
  bit          o_stall_ok, o_hold_ok, o_after_ok;

  function automatic bit is_valid(input logic [7:0] m);
    return m inside {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd8, 8'd9, 8'd10};
  endfunction

  // Expected outcome of one access whose module acks in ACCESS cycle d (0-based).
  task automatic model(input logic [7:0] m, input logic w, input int d, input logic [31:0] data,
                       output int lat, output logic e, output logic [31:0] rd, output logic [15:0] s);
    s = is_valid(m) ? 16'h1 << m[3:0] : 16'h0;
    if (!is_valid(m)) begin lat = 1; e = 1'b1; rd = 32'h0; end
    else if (TO_EN && d >= TO) begin lat = TO + 1; e = 1'b1; rd = 32'hDEADBEEF; end
    else begin lat = d + 2; e = 1'b0; rd = w ? 32'h0 : data; end
  endtask

  task automatic idle_inputs();
    bus.cpu_de = 1'b0; bus.cpu_we = 1'b0; bus.cpu_mod = 8'h0;
    bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0; bus.mod_ack = 16'h0; bus.mod_rdata = 32'h0;
  endtask

  // Drives one request from a negedge, plays a module that acks in ACCESS cycle d, records what it saw.
  task automatic run_txn(input logic [7:0] m, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input int d, input logic [31:0] data, input bit noise, input logic [15:0] extra);
    bus.cpu_de = 1'b1; bus.cpu_we = w; bus.cpu_mod = m; bus.cpu_addr = a; bus.cpu_wdata = wd;
    bus.mod_ack = noise ? 16'($urandom) : extra;
    bus.mod_rdata = noise ? $urandom : 32'h0;
    o_lat = 0; o_err = 1'b0; o_rdata = 32'h0; o_stall_ok = 1'b1; o_hold_ok = 1'b1; o_after_ok = 1'b1;
    o_sel = 16'h0; o_we = 1'b0; o_addr = 32'h0; o_wdata = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        o_sel = bus.mod_sel; o_we = bus.mod_we; o_addr = bus.mod_addr; o_wdata = bus.mod_wdata;
      end
      if (bus.cpu_rdy === 1'b1) begin
        o_lat = i; o_err = bus.cpu_err; o_rdata = bus.cpu_rdata;
        if (bus.cpu_stall !== 1'b0 || bus.mod_sel !== 16'h0) o_stall_ok = 1'b0;
        break;
      end
      if (bus.cpu_stall !== 1'b1) o_stall_ok = 1'b0;
      if (bus.mod_sel !== o_sel || bus.mod_we !== o_we || bus.mod_addr !== o_addr || bus.mod_wdata !== o_wdata)
        o_hold_ok = 1'b0;
      bus.cpu_de = noise ? 1'($urandom_range(1)) : 1'b0;
      if (noise) begin
        bus.cpu_we = 1'($urandom_range(1)); bus.cpu_mod = 8'($urandom_range(10));
        bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
      end
      bus.mod_ack = ((i - 1 == d) ? bus.mod_sel : 16'h0) | (noise ? 16'($urandom) & ~bus.mod_sel : 16'h0) | extra;
      bus.mod_rdata = (i - 1 == d) ? data : (noise ? $urandom : 32'h0);
    end
    bus.cpu_de = 1'b0;
    bus.mod_ack = noise ? 16'($urandom) : 16'h0;
    @(negedge clk);
    if (bus.cpu_rdy !== 1'b0 || bus.cpu_err !== 1'b0 || bus.cpu_stall !== 1'b0 ||
        bus.mod_sel !== 16'h0 || bus.cpu_rdata !== o_rdata) o_after_ok = 1'b0;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.mod_sel, bus.mod_we, bus.mod_addr, bus.mod_wdata, bus.cpu_rdata,
         bus.cpu_stall, bus.cpu_rdy, bus.cpu_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_values sel=%h rdata=%h stall=%b rdy=%b err=%b required all zero",
               bus.mod_sel, bus.cpu_rdata, bus.cpu_stall, bus.cpu_rdy, bus.cpu_err);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    int lat; logic e; logic [31:0] rd; logic [15:0] s;
    model(8'd1, 1'b0, 3, 32'h12345678, lat, e, rd, s);
    run_txn(8'd1, 1'b0, 32'h40, 32'h0, 3, 32'h12345678, 1'b0, 16'h0);
    n_chk++; if (o_sel !== 16'h0002) begin n_fail++; $display("FAIL read_sel got=%h exp=0002", o_sel); end
    n_chk++; if (o_rdata !== rd) begin n_fail++; $display("FAIL read_rdata got=%h exp=%h", o_rdata, rd); end
    n_chk++; if (o_err !== e || o_lat != lat) begin n_fail++; $display("FAIL read_resp err=%b lat=%0d exp err=%b lat=%0d", o_err, o_lat, e, lat); end
    n_chk++; if (!o_stall_ok || !o_after_ok) begin n_fail++; $display("FAIL read_stall stall_ok=%b after_ok=%b exp 1 1", o_stall_ok, o_after_ok); end
  endtask

  task automatic test_write();
    run_txn(8'd4, 1'b1, 32'h100, 32'hA5, 0, 32'hFFFF_FFFF, 1'b0, 16'h0);
    n_chk++; if (o_sel !== 16'h0010 || o_we !== 1'b1 || o_wdata !== 32'hA5 || o_addr !== 32'h100) begin
      n_fail++; $display("FAIL write_latch sel=%h we=%b wdata=%h addr=%h exp 0010 1 000000a5 00000100", o_sel, o_we, o_wdata, o_addr);
    end
    n_chk++; if (o_lat != 2 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
      n_fail++; $display("FAIL write_resp lat=%0d err=%b rdata=%h exp 2 0 0", o_lat, o_err, o_rdata);
    end
  endtask

  task automatic test_invalid();
    logic [7:0] bad [3] = '{8'd6, 8'd15, 8'd200};
    for (int k = 0; k < 3; k++) begin
      run_txn(bad[k], 1'b0, 32'h8, 32'h0, 0, 32'h55AA55AA, 1'b0, 16'hFFFF);
      n_chk++; if (o_sel !== 16'h0 || o_lat != 1 || o_err !== 1'b1 || o_rdata !== 32'h0 || !o_after_ok) begin
        n_fail++; $display("FAIL invalid_mod mod=%0d sel=%h lat=%0d err=%b rdata=%h exp 0000 1 1 0", bad[k], o_sel, o_lat, o_err, o_rdata);
      end
    end
  endtask

  task automatic test_timeout();
    int lat; logic e; logic [31:0] rd; logic [15:0] s;
    int dn;
    dn = TO_EN ? 100 : 6;
    model(8'd2, 1'b0, dn, 32'hCAFE0001, lat, e, rd, s);
    run_txn(8'd2, 1'b0, 32'h20, 32'h0, dn, 32'hCAFE0001, 1'b0, 16'h0008);
    n_chk++; if (o_lat != lat || o_err !== e || o_rdata !== rd || o_sel !== s) begin
      n_fail++; $display("FAIL timeout_foreign_ack lat=%0d err=%b rdata=%h sel=%h exp %0d %b %h %h", o_lat, o_err, o_rdata, o_sel, lat, e, rd, s);
    end
    model(8'd9, 1'b0, TO - 1, 32'h9999_0009, lat, e, rd, s);
    run_txn(8'd9, 1'b0, 32'h90, 32'h0, TO - 1, 32'h9999_0009, 1'b0, 16'h0);
    n_chk++; if (o_lat != lat || o_err !== 1'b0 || o_rdata !== 32'h9999_0009) begin
      n_fail++; $display("FAIL ack_at_expiry lat=%0d err=%b rdata=%h exp %0d 0 99990009", o_lat, o_err, o_rdata, lat);
    end
  endtask

  task automatic test_random();
    int lat, d; logic e, w; logic [31:0] rd, a, wd, data; logic [15:0] s; logic [7:0] m;
    for (int t = 0; t < 40; t++) begin
      m = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(11));
      w = 1'($urandom_range(1)); a = $urandom; wd = $urandom; data = $urandom; d = $urandom_range(6);
      model(m, w, d, data, lat, e, rd, s);
      run_txn(m, w, a, wd, d, data, 1'b1, 16'h0);
      n_chk++; if (o_lat != lat || o_err !== e || o_rdata !== rd) begin
        n_fail++; $display("FAIL rand_resp t=%0d mod=%0d lat=%0d err=%b rdata=%h exp %0d %b %h", t, m, o_lat, o_err, o_rdata, lat, e, rd);
      end
      n_chk++; if (o_sel !== s || (s != 0 && (o_we !== w || o_addr !== a || o_wdata !== wd))) begin
        n_fail++; $display("FAIL rand_latch t=%0d sel=%h we=%b addr=%h wdata=%h exp %h %b %h %h", t, o_sel, o_we, o_addr, o_wdata, s, w, a, wd);
      end
      n_chk++; if (!o_stall_ok || !o_hold_ok || !o_after_ok) begin
        n_fail++; $display("FAIL rand_timing t=%0d stall_ok=%b hold_ok=%b after_ok=%b exp 1 1 1", t, o_stall_ok, o_hold_ok, o_after_ok);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit rdy_seen;
    run_txn(8'd3, 1'b0, 32'h30, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 16'h0);
    bus.cpu_de = 1'b1; bus.cpu_we = 1'b1; bus.cpu_mod = 8'd1; bus.cpu_addr = 32'h1234; bus.cpu_wdata = 32'h77;
    @(negedge clk);
    bus.cpu_de = 1'b0;
    n_chk++; if (bus.mod_sel !== 16'h0002 || bus.cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_access sel=%h stall=%b exp 0002 1", bus.mod_sel, bus.cpu_stall);
    end
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({bus.mod_sel, bus.mod_we, bus.mod_addr, bus.mod_wdata, bus.cpu_rdata,
                  bus.cpu_stall, bus.cpu_rdy, bus.cpu_err} !== '0) begin
      n_fail++; $display("FAIL async_reset sel=%h we=%b addr=%h rdata=%h stall=%b exp all zero",
                         bus.mod_sel, bus.mod_we, bus.mod_addr, bus.cpu_rdata, bus.cpu_stall);
    end
    bus.mod_ack = 16'h0002; bus.mod_rdata = 32'h1111_2222;
    rdy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b1;
      rdy_seen |= bus.cpu_rdy;
    end
    idle_inputs();
    n_chk++; if (rdy_seen) begin n_fail++; $display("FAIL reset_no_rdy got rdy=1 exp 0"); end
    run_txn(8'd8, 1'b0, 32'h80, 32'h0, 1, 32'h3C3C_5A5A, 1'b0, 16'h0);
    n_chk++; if (o_lat != 3 || o_err !== 1'b0 || o_rdata !== 32'h3C3C_5A5A || o_sel !== 16'h0100) begin
      n_fail++; $display("FAIL post_reset_txn lat=%0d err=%b rdata=%h sel=%h exp 3 0 3c3c5a5a 0100", o_lat, o_err, o_rdata, o_sel);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_invalid();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
